// File: rtl/pipeline_stall_ctrl.sv
// Hazard/stall controller for the 5-stage pipeline: load-use bubbles, counted MUL/DIV occupancy
// stalls and taken-branch squashing of IF/ID.
module pipeline_stall_ctrl #(
   parameter int REG_AW     = 5,
   parameter int MUL_CYCLES = 4,
   parameter int DIV_CYCLES = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_uses_rs,
   input  logic              id_uses_rt,
   input  logic              ex_is_load,
   input  logic [REG_AW-1:0] ex_dst,
   input  logic              id_mdu_start,
   input  logic              id_mdu_div,
   input  logic              id_br_taken,
   output logic              stall,
   output logic              ifid_wena,
   output logic              ifid_flush,
   output logic              idex_flush,
   output logic              mdu_busy,
   output logic              mdu_done
);

   localparam int CW = $clog2(DIV_CYCLES + 1);
   localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 1);
   localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);

   typedef enum logic {
      RUN,
      MDU_BUSY
   } state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic            load_use;
   logic            busy;

   // A load still in EX cannot forward to ID; register 0 never creates a dependency.
   always_comb begin
      load_use = ex_is_load && (ex_dst != '0) &&
                 ((id_uses_rs && (id_rs == ex_dst)) || (id_uses_rt && (id_rt == ex_dst)));
   end

   // cnt holds the remaining busy cycles minus one, so the MDU stalls exactly N cycles.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= RUN;
         cnt   <= '0;
      end else begin
         case (state)
            RUN: begin
               if (!load_use && id_mdu_start) begin
                  state <= MDU_BUSY;
                  cnt   <= id_mdu_div ? DIV_LOAD : MUL_LOAD;
               end
            end
            MDU_BUSY: begin
               if (cnt == '0) begin
                  state <= RUN;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: begin
               state <= RUN;
               cnt   <= '0;
            end
         endcase
      end
   end

   // MDU occupancy overrides everything; a load-use bubble overrides a branch squash.
   always_comb begin
      busy       = (state == MDU_BUSY);
      stall      = busy || load_use;
      ifid_wena  = !stall;
      idex_flush = stall;
      ifid_flush = !stall && id_br_taken;
      mdu_busy   = busy;
      mdu_done   = busy && (cnt == '0);
   end

endmodule
